// File: rtl/sprite_motion.sv
// Per-frame sprite position engine: shadows the CPU-written ship position,
// bounces the planet off the screen edges, and flags ship/planet overlap.
module sprite_motion #(
    parameter int HD  = 640,
    parameter int VD  = 480,
    parameter int SPR = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [15:0] x_ship,
    output logic [15:0] y_ship,
    output logic [15:0] x_planet,
    output logic [15:0] y_planet,
    output logic        collision
);

    localparam logic [15:0] X_MAX   = 16'(HD - SPR);
    localparam logic [15:0] Y_MAX   = 16'(VD - SPR);
    localparam logic [15:0] SPR_W   = 16'(SPR);
    localparam logic [15:0] X_SHIP0 = 16'(HD / 2 - SPR / 2);
    localparam logic [15:0] Y_SHIP0 = 16'(VD / 2 - SPR / 2);

    typedef enum logic [1:0] {
        S_WAIT,
        S_UPD_X,
        S_UPD_Y,
        S_COLL
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_q;
    logic [15:0] stg_x_q, stg_x_d;
    logic [15:0] stg_y_q, stg_y_d;
    logic [15:0] ship_x_q, ship_x_d;
    logic [15:0] ship_y_q, ship_y_d;
    logic [15:0] pl_x_q, pl_x_d;
    logic [15:0] pl_y_q, pl_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [3:0]  hs_q, hs_d;
    logic [3:0]  vs_q, vs_d;
    logic [3:0]  hs_w_q, hs_w_d;
    logic [3:0]  vs_w_q, vs_w_d;
    logic        run_q, run_d;
    logic        coll_q, coll_d;
    logic [15:0] rdata_q, rdata_d;
    logic        tick;

    // Returns {new_dir, new_pos}; dir=1 means moving towards zero (left/up).
    function automatic logic [16:0] step_axis(input logic [15:0] pos,
                                              input logic [3:0]  spd,
                                              input logic        dir_neg,
                                              input logic [15:0] lim);
        logic [16:0] sum;
        sum = {1'b0, pos} + {13'b0, spd};
        if (!dir_neg) begin
            if (sum >= {1'b0, lim}) return {1'b1, lim};
            else                    return {1'b0, sum[15:0]};
        end else begin
            if (pos <= {12'b0, spd}) return {1'b0, 16'd0};
            else                     return {1'b1, pos - {12'b0, spd}};
        end
    endfunction

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign tick = vsync & ~vsync_q;

    always_comb begin
        state_d  = state_q;
        stg_x_d  = stg_x_q;
        stg_y_d  = stg_y_q;
        ship_x_d = ship_x_q;
        ship_y_d = ship_y_q;
        pl_x_d   = pl_x_q;
        pl_y_d   = pl_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        hs_w_d   = hs_w_q;
        vs_w_d   = vs_w_q;
        run_d    = run_q;
        coll_d   = coll_q;
        rdata_d  = 16'd0;

        if (tick) begin
            ship_x_d = (stg_x_q > X_MAX) ? X_MAX : stg_x_q;
            ship_y_d = (stg_y_q > Y_MAX) ? Y_MAX : stg_y_q;
        end

        if (wr_en) begin
            case (addr)
                2'd0: stg_x_d = wdata;
                2'd1: stg_y_d = wdata;
                2'd2: begin
                    run_d = wdata[0];
                    if (wdata[1]) coll_d = 1'b0;
                end
                default: begin
                    hs_d = wdata[3:0];
                    vs_d = wdata[7:4];
                end
            endcase
        end

        // The FSM runs after the clear so a same-cycle collision set wins.
        case (state_q)
            S_WAIT: begin
                if (tick && run_q) begin
                    hs_w_d  = hs_q;
                    vs_w_d  = vs_q;
                    state_d = S_UPD_X;
                end
            end
            S_UPD_X: begin
                {dir_x_d, pl_x_d} = step_axis(pl_x_q, hs_w_q, dir_x_q, X_MAX);
                state_d = S_UPD_Y;
            end
            S_UPD_Y: begin
                {dir_y_d, pl_y_d} = step_axis(pl_y_q, vs_w_q, dir_y_q, Y_MAX);
                state_d = S_COLL;
            end
            S_COLL: begin
                if ((abs_diff(ship_x_q, pl_x_q) < SPR_W) &&
                    (abs_diff(ship_y_q, pl_y_q) < SPR_W))
                    coll_d = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase

        case (addr)
            2'd0:    rdata_d = ship_x_q;
            2'd1:    rdata_d = ship_y_q;
            2'd2:    rdata_d = {14'b0, coll_q, run_q};
            default: rdata_d = pl_x_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            vsync_q  <= 1'b0;
            stg_x_q  <= X_SHIP0;
            stg_y_q  <= Y_SHIP0;
            ship_x_q <= X_SHIP0;
            ship_y_q <= Y_SHIP0;
            pl_x_q   <= 16'd0;
            pl_y_q   <= 16'd0;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            hs_q     <= 4'd2;
            vs_q     <= 4'd1;
            hs_w_q   <= 4'd2;
            vs_w_q   <= 4'd1;
            run_q    <= 1'b0;
            coll_q   <= 1'b0;
            rdata_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= vsync;
            stg_x_q  <= stg_x_d;
            stg_y_q  <= stg_y_d;
            ship_x_q <= ship_x_d;
            ship_y_q <= ship_y_d;
            pl_x_q   <= pl_x_d;
            pl_y_q   <= pl_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hs_w_q   <= hs_w_d;
            vs_w_q   <= vs_w_d;
            run_q    <= run_d;
            coll_q   <= coll_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign x_ship    = ship_x_q;
    assign y_ship    = ship_y_q;
    assign x_planet  = pl_x_q;
    assign y_planet  = pl_y_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: a vector table for frame-level behaviour
// plus cycle-exact sequences for reset, collision timing and mid-walk reset.
module tb_sprite_motion;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] x_ship, y_ship, x_planet, y_planet;
    logic        collision;

    int n_checks = 0;
    int n_fail   = 0;

    sprite_motion dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .wr_en     (wr_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .x_ship    (x_ship),
        .y_ship    (y_ship),
        .x_planet  (x_planet),
        .y_planet  (y_planet),
        .collision (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        bit          do_wr;
        logic [1:0]  waddr;
        logic [15:0] wval;
        int          frames;
        logic [1:0]  raddr;
        logic [15:0] xs, ys, xp, yp;
        logic        coll;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(bit r, bit w, logic [1:0] wa, logic [15:0] wv, int fr,
                                logic [1:0] ra, logic [15:0] xs, logic [15:0] ys,
                                logic [15:0] xp, logic [15:0] yp, logic c, logic [15:0] rd);
        vec_t v;
        v.do_rst = r;  v.do_wr = w;  v.waddr = wa; v.wval = wv; v.frames = fr;
        v.raddr = ra;  v.xs = xs;    v.ys = ys;    v.xp = xp;   v.yp = yp;
        v.coll = c;    v.rd = rd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] a);
        @(posedge clk); #1 addr = a;
        @(posedge clk); #1;
    endtask

    task automatic frame();
        @(posedge clk); #1 vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        if (v.do_rst) doReset();
        if (v.do_wr) writeReg(v.waddr, v.wval);
        repeat (v.frames) frame();
        readReg(v.raddr);
        checkOutput($sformatf("v%0d x_ship", idx),    x_ship,         v.xs);
        checkOutput($sformatf("v%0d y_ship", idx),    y_ship,         v.ys);
        checkOutput($sformatf("v%0d x_planet", idx),  x_planet,       v.xp);
        checkOutput($sformatf("v%0d y_planet", idx),  y_planet,       v.yp);
        checkOutput($sformatf("v%0d collision", idx), 16'(collision), 16'(v.coll));
        checkOutput($sformatf("v%0d rdata", idx),     rdata,          v.rd);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; vsync = 1'b0; wr_en = 1'b0; addr = 2'd0; wdata = 16'd0;

        // Right-wall bounce with hs=15, vs=0, then both speeds frozen.
        vecs[0]  = mk(1, 1, 2'd3, 16'h000F, 0,  2'd3, 312, 232, 0,   0, 0, 0);
        vecs[1]  = mk(0, 1, 2'd2, 16'h0001, 41, 2'd3, 312, 232, 615, 0, 0, 615);
        vecs[2]  = mk(0, 0, 2'd0, 16'h0000, 1,  2'd3, 312, 232, 624, 0, 0, 624);
        vecs[3]  = mk(0, 0, 2'd0, 16'h0000, 1,  2'd3, 312, 232, 609, 0, 0, 609);
        vecs[4]  = mk(0, 1, 2'd3, 16'h0000, 1,  2'd2, 312, 232, 609, 0, 0, 1);
        // Basic motion, shadowing and clamping, run stop.
        vecs[5]  = mk(1, 1, 2'd2, 16'h0001, 3,  2'd2, 312, 232, 6,   3, 0, 1);
        vecs[6]  = mk(0, 1, 2'd0, 16'd700,  0,  2'd0, 312, 232, 6,   3, 0, 312);
        vecs[7]  = mk(0, 1, 2'd1, 16'd500,  0,  2'd1, 312, 232, 6,   3, 0, 232);
        vecs[8]  = mk(0, 0, 2'd0, 16'h0000, 1,  2'd0, 624, 464, 8,   4, 0, 624);
        vecs[9]  = mk(0, 0, 2'd0, 16'h0000, 0,  2'd1, 624, 464, 8,   4, 0, 464);
        vecs[10] = mk(0, 1, 2'd2, 16'h0000, 1,  2'd2, 624, 464, 8,   4, 0, 0);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

        // Asynchronous reset between clock edges.
        readReg(2'd0);
        checkOutput("pre-reset rdata", rdata, 624);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        checkOutput("async x_ship",    x_ship,         312);
        checkOutput("async y_ship",    y_ship,         232);
        checkOutput("async x_planet",  x_planet,       0);
        checkOutput("async y_planet",  y_planet,       0);
        checkOutput("async collision", 16'(collision), 0);
        checkOutput("async rdata",     rdata,          0);
        @(posedge clk); #1 reset = 1'b0;

        // Collision: ship at (20,0), default speeds.
        writeReg(2'd0, 16'd20);
        writeReg(2'd1, 16'd0);
        writeReg(2'd2, 16'h0001);
        frame();
        checkOutput("f1 x_planet",  x_planet,       2);
        checkOutput("f1 y_planet",  y_planet,       1);
        checkOutput("f1 collision", 16'(collision), 0);
        frame();
        checkOutput("f2 x_planet",  x_planet,       4);
        checkOutput("f2 y_planet",  y_planet,       2);
        checkOutput("f2 collision", 16'(collision), 0);
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1;
        checkOutput("T+1 x_ship",   x_ship,   20);
        checkOutput("T+1 x_planet", x_planet, 4);
        @(posedge clk); #1;
        checkOutput("T+2 x_planet", x_planet, 6);
        checkOutput("T+2 y_planet", y_planet, 2);
        @(posedge clk); #1 vsync = 1'b0;
        checkOutput("T+3 y_planet",  y_planet,       3);
        checkOutput("T+3 collision", 16'(collision), 0);
        @(posedge clk); #1;
        checkOutput("T+4 collision", 16'(collision), 1);
        repeat (4) @(posedge clk);
        writeReg(2'd2, 16'h0003);
        checkOutput("clear collision", 16'(collision), 0);
        readReg(2'd2);
        checkOutput("status after clear", rdata, 16'h0001);
        frame();
        checkOutput("f4 x_planet",  x_planet,       8);
        checkOutput("f4 collision", 16'(collision), 1);
        readReg(2'd2);
        checkOutput("f4 status", rdata, 16'h0003);

        // Reset in the cycle after tick; next vsync must not move the planet.
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        #1;
        checkOutput("midwalk x_planet",  x_planet,       0);
        checkOutput("midwalk y_planet",  y_planet,       0);
        checkOutput("midwalk collision", 16'(collision), 0);
        #1 reset = 1'b0;
        @(posedge clk); #1 vsync = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post-reset x_planet", x_planet, 0);
        frame();
        checkOutput("idle x_planet", x_planet, 0);
        checkOutput("idle y_planet", y_planet, 0);
        checkOutput("idle x_ship",   x_ship,   312);
        readReg(2'd2);
        checkOutput("idle status", rdata, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_motion.md
# sprite_motion

Computes sprite positions for the VGA renderer once per frame. Sits directly upstream of the VGA sync/colour stage, which consumes the positions it produces. The CPU writes the spaceship position through a small register file; the block moves the planet by itself, bouncing it off the screen edges, and flags a ship/planet bounding-box collision. All updates are locked to the vsync pulse, so a sprite never moves mid-frame.

## Interface
- HD, 640: horizontal display width in pixels
- VD, 480: vertical display height in pixels
- SPR, 16: sprite edge length in pixels (square sprites)
- clk  in  1  system clock (same clock as the VGA stage)
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  vsync from the VGA stage, active-high during flyback
- wr_en  in  1  CPU register write strobe, one cycle
- addr  in  2  register address
- wdata  in  16  write data
- rdata  out  16  registered read data for `addr`
- x_ship, y_ship  out  16 each  live spaceship top-left corner
- x_planet, y_planet  out  16 each  live planet top-left corner
- collision  out  1  sticky collision flag

## Operation
- Frame tick:
  - vsync_q <= vsync.
  - tick = vsync & ~vsync_q.
  - Exactly one tick per vsync rising edge.
- Register writes (when wr_en=1):
  - addr 0: staged ship x.
  - addr 1: staged ship y.
  - addr 2: control. Bit0 = run. Bit1 = clear collision (self-clearing, not stored).
  - addr 3: speeds. [3:0] = hs, [7:4] = vs. Unsigned 0–15.
- Register reads (rdata, every cycle, by addr):
  - 0: x_ship.
  - 1: y_ship.
  - 2: status = {8'b0, 6'b0, collision, run}.
  - 3: x_planet.
- Shadow and clamp:
  - On every tick, regardless of run, the live ship position loads from the staged registers.
  - x is clamped to HD-SPR = 624; y is clamped to VD-SPR = 464.
  - Staged values never appear on the outputs before a tick.
- Planet FSM:
  - States: WAIT, UPD_X, UPD_Y, COLL.
  - WAIT: if tick and run=1, latch hs/vs into working registers and go to UPD_X. Otherwise stay.
  - UPD_X, moving right: if x+hs >= 624, then x = 624 and direction becomes left; else x += hs.
  - UPD_X, moving left: if x <= hs, then x = 0 and direction becomes right; else x -= hs.
  - Then go to UPD_Y.
  - UPD_Y: same rules with vs, limit 464, down/up. Then go to COLL.
  - COLL: if |x_ship-x_planet| < SPR and |y_ship-y_planet| < SPR, set collision. Then go to WAIT.
- Arithmetic: 16-bit unsigned. Compute x+hs at 17 bits so it cannot wrap.
- Boundary rules:
  - A tick outside WAIT is ignored. This cannot happen in normal video timing: the walk is 3 cycles and vsync is 1600+ cycles apart.
  - A speed write during UPD_X/UPD_Y/COLL takes effect next frame.
  - hs=0 or vs=0 freezes that axis; direction still flips if the planet is already at a wall.
  - Clear and set in the same cycle: set wins.
  - run=0 mid-walk: the walk completes; the next tick is ignored.
  - Reset at any time returns everything to reset values immediately (asynchronous).
- Reset values:
  - x_ship = 312, y_ship = 232; staged registers equal the same.
  - x_planet = 0, y_planet = 0; directions right/down.
  - hs = 2, vs = 1, run = 0, collision = 0, rdata = 0, FSM = WAIT, vsync_q = 0.

## Timing
- Tick is asserted in cycle T, the first clk in which vsync=1 and vsync_q=0.
- x_ship/y_ship update at the T edge and are visible in T+1.
- x_planet is visible in T+2, y_planet in T+3, collision in T+4.
- All position outputs are stable within 4 cycles of vsync rise, well before active video.
- Writes take effect in the cycle after wr_en. A clear removes collision in the cycle after the write.
- rdata latency is one cycle after addr is applied.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> x_ship=312, y_ship=232, x_planet=0, y_planet=0, collision=0, rdata=0 without waiting for a clock edge.
- Basic motion: write addr2=1, then 3 vsync pulses -> x_planet=6, y_planet=3. Read addr2 -> 0x0001.
- Right-wall bounce: write hs=15, vs=0, run=1. After 41 frames x_planet=615. Frame 42 -> 624. Frame 43 -> 609. y_planet stays 0.
- Shadow and clamp: write addr0=700, addr1=500. x_ship/y_ship remain 312/232 until the next tick, then become 624/464. Read addr0 -> 624.
- Collision: ship (20,0), default speeds, run=1. Frames 1–2: collision=0, with planet at (2,1) then (4,2). Frame 3: planet (6,3), collision=1 in T+4. Write addr2=3 -> collision=0 next cycle. Frame 4: reasserts.
- Reset mid-walk: assert reset in the cycle after tick -> x_planet=0, FSM=WAIT. The next vsync does nothing because run=0.
